// File: rtl/mac_seq_ctrl_if.sv
// Bundle between mac_seq_ctrl and its neighbours: triplet input stream, MAC operand/control bus,
// and dot-product result stream. "master" is the sequencer side, "slave" the environment side.
interface mac_seq_ctrl_if #(
    parameter int W_BITWIDTH   = 8,
    parameter int IN_BITWIDTH  = 8,
    parameter int OUT_BITWIDTH = 32,
    parameter int CNT_BITWIDTH = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [W_BITWIDTH-1:0]   in_w0, in_w1, in_w2;
    logic [IN_BITWIDTH-1:0]  in_d0, in_d1, in_d2;
    logic                    in_last;

    logic                    mac_en;
    logic [W_BITWIDTH-1:0]   mac_w0, mac_w1, mac_w2;
    logic [IN_BITWIDTH-1:0]  mac_d0, mac_d1, mac_d2;
    logic [OUT_BITWIDTH-1:0] mac_pre_sum;
    logic                    mac_done;
    logic [OUT_BITWIDTH-1:0] mac_out;

    logic                    res_valid;
    logic                    res_ready;
    logic [OUT_BITWIDTH-1:0] res_data;
    logic [CNT_BITWIDTH-1:0] res_count;

    modport master (
        input  in_valid, in_w0, in_w1, in_w2, in_d0, in_d1, in_d2, in_last,
        input  mac_done, mac_out, res_ready,
        output in_ready, mac_en, mac_w0, mac_w1, mac_w2, mac_d0, mac_d1, mac_d2,
        output mac_pre_sum, res_valid, res_data, res_count
    );

    modport slave (
        output in_valid, in_w0, in_w1, in_w2, in_d0, in_d1, in_d2, in_last,
        output mac_done, mac_out, res_ready,
        input  in_ready, mac_en, mac_w0, mac_w1, mac_w2, mac_d0, mac_d1, mac_d2,
        input  mac_pre_sum, res_valid, res_data, res_count
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequencer feeding (3 weight, 3 data) triplets to a 3-lane MAC and chaining results into a
// per-vector dot product. Define MAC_SEQ_BIAS_EN to add bias_in as the accumulator seed.
module mac_seq_ctrl #(
    parameter int W_BITWIDTH   = 8,
    parameter int IN_BITWIDTH  = 8,
    parameter int OUT_BITWIDTH = 32,
    parameter int CNT_BITWIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
`ifdef MAC_SEQ_BIAS_EN
    input  logic [OUT_BITWIDTH-1:0] bias_in,
`endif
    mac_seq_ctrl_if.master          bus
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_LAUNCH  = 3'd1,
        S_WAIT_HI = 3'd2,
        S_WAIT_LO = 3'd3,
        S_RESULT  = 3'd4
    } state_t;

    localparam logic [CNT_BITWIDTH-1:0] CNT_ZERO = {CNT_BITWIDTH{1'b0}};
    localparam logic [CNT_BITWIDTH-1:0] CNT_ONE  = {{(CNT_BITWIDTH-1){1'b0}}, 1'b1};
    localparam logic [OUT_BITWIDTH-1:0] ACC_ZERO = {OUT_BITWIDTH{1'b0}};

    state_t                  r_state;
    logic [OUT_BITWIDTH-1:0] r_acc;
    logic [CNT_BITWIDTH-1:0] r_cnt;
    logic                    r_last;
    logic [OUT_BITWIDTH-1:0] w_seed;

    // The first triplet of a vector seeds the accumulator; later triplets keep the running sum.
`ifdef MAC_SEQ_BIAS_EN
    assign w_seed = (r_cnt == CNT_ZERO) ? bias_in : r_acc;
`else
    assign w_seed = r_acc;
`endif

    assign bus.mac_pre_sum = r_acc;
    assign bus.res_data    = r_acc;
    assign bus.res_count   = r_cnt;

    // Sequencer FSM with registered handshake and MAC operand outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= S_FETCH;
            r_acc         <= ACC_ZERO;
            r_cnt         <= CNT_ZERO;
            r_last        <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.mac_en    <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.mac_w0    <= {W_BITWIDTH{1'b0}};
            bus.mac_w1    <= {W_BITWIDTH{1'b0}};
            bus.mac_w2    <= {W_BITWIDTH{1'b0}};
            bus.mac_d0    <= {IN_BITWIDTH{1'b0}};
            bus.mac_d1    <= {IN_BITWIDTH{1'b0}};
            bus.mac_d2    <= {IN_BITWIDTH{1'b0}};
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (bus.in_valid && bus.in_ready) begin
                        bus.mac_w0   <= bus.in_w0;
                        bus.mac_w1   <= bus.in_w1;
                        bus.mac_w2   <= bus.in_w2;
                        bus.mac_d0   <= bus.in_d0;
                        bus.mac_d1   <= bus.in_d1;
                        bus.mac_d2   <= bus.in_d2;
                        r_last       <= bus.in_last;
                        r_cnt        <= r_cnt + CNT_ONE;
                        r_acc        <= w_seed;
                        bus.in_ready <= 1'b0;
                        bus.mac_en   <= 1'b1;
                        r_state      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    bus.mac_en <= 1'b0;
                    r_state    <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (bus.mac_done) begin
                        r_state <= S_WAIT_LO;
                    end
                end
                // mac_out is taken on the falling side of done, when the MAC guarantees it is settled.
                S_WAIT_LO: begin
                    if (!bus.mac_done) begin
                        r_acc <= bus.mac_out;
                        if (r_last) begin
                            bus.res_valid <= 1'b1;
                            r_state       <= S_RESULT;
                        end else begin
                            bus.in_ready <= 1'b1;
                            r_state      <= S_FETCH;
                        end
                    end
                end
                S_RESULT: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        r_acc         <= ACC_ZERO;
                        r_cnt         <= CNT_ZERO;
                        r_state       <= S_FETCH;
                    end
                end
                default: begin
                    bus.in_ready  <= 1'b1;
                    bus.mac_en    <= 1'b0;
                    bus.res_valid <= 1'b0;
                    r_state       <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl with a behavioural 3-lane MAC of random latency.
// Expected dot products come from plain integer sums of the triplets (plus bias when enabled).
module tb_mac_seq_ctrl;
    localparam int WB = 8;
    localparam int IB = 8;
    localparam int OB = 32;
    localparam int CB = 16;
`ifdef MAC_SEQ_BIAS_EN
    localparam bit BIAS_ON = 1'b1;
    logic [OB-1:0] bias_in;
`else
    localparam bit BIAS_ON = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    mac_seq_ctrl_if #(.W_BITWIDTH(WB), .IN_BITWIDTH(IB), .OUT_BITWIDTH(OB), .CNT_BITWIDTH(CB)) bus ();

    mac_seq_ctrl #(.W_BITWIDTH(WB), .IN_BITWIDTH(IB), .OUT_BITWIDTH(OB), .CNT_BITWIDTH(CB)) dut (
        .clk     (clk),
        .rstn    (rstn),
`ifdef MAC_SEQ_BIAS_EN
        .bias_in (bias_in),
`endif
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural MAC: result = pre_sum + sum(w*d), done pulses high after a random latency.
    int             mac_en_total = 0;
    int             overlap_err  = 0;
    int             hold_err     = 0;
    int             force_lat    = -1;
    int             m_phase, m_cnt;
    logic [OB-1:0]  m_calc;
    logic [79:0]    m_ops;
    logic [OB-1:0]  pre_q[$];

    always @(posedge clk or negedge rstn) begin : mac_model
        int          lat;
        int          prod;
        logic [OB-1:0] c;
        if (!rstn) begin
            bus.mac_done <= 1'b0;
            bus.mac_out  <= '0;
            m_phase      <= 0;
            m_cnt        <= 0;
        end else if (bus.mac_en) begin
            mac_en_total++;
            if (m_phase != 0) overlap_err++;
            prod = int'($signed(bus.mac_w0)) * int'($signed(bus.mac_d0))
                 + int'($signed(bus.mac_w1)) * int'($signed(bus.mac_d1))
                 + int'($signed(bus.mac_w2)) * int'($signed(bus.mac_d2));
            c = bus.mac_pre_sum + prod;
            pre_q.push_back(bus.mac_pre_sum);
            m_calc <= c;
            m_ops  <= {bus.mac_w0, bus.mac_w1, bus.mac_w2, bus.mac_d0, bus.mac_d1, bus.mac_d2, bus.mac_pre_sum};
            lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
            if (lat == 0) begin
                bus.mac_done <= 1'b1;
                bus.mac_out  <= c;
                m_phase      <= 2;
                m_cnt        <= int'($urandom_range(0, 2));
            end else begin
                m_phase <= 1;
                m_cnt   <= lat - 1;
            end
        end else begin
            if (m_phase != 0 &&
                {bus.mac_w0, bus.mac_w1, bus.mac_w2, bus.mac_d0, bus.mac_d1, bus.mac_d2, bus.mac_pre_sum} !== m_ops)
                hold_err++;
            if (m_phase == 1) begin
                if (m_cnt == 0) begin
                    bus.mac_done <= 1'b1;
                    bus.mac_out  <= m_calc;
                    m_phase      <= 2;
                    m_cnt        <= int'($urandom_range(0, 2));
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end else if (m_phase == 2) begin
                if (m_cnt == 0) begin
                    bus.mac_done <= 1'b0;
                    m_phase      <= 0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    byte vw[16][3];
    byte vd[16][3];

    task automatic send_triplet(input int t, input bit last);
        int waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("fetch_ready", bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_w0 = vw[t][0]; bus.in_w1 = vw[t][1]; bus.in_w2 = vw[t][2];
        bus.in_d0 = vd[t][0]; bus.in_d1 = vd[t][1]; bus.in_d2 = vd[t][2];
        bus.in_last = last;
        @(posedge clk); #1;
        check("launch_mac_en", bus.mac_en, 1'b1);
        check("busy_in_ready", bus.in_ready, 1'b0);
        // junk held on the input while busy must be ignored
        bus.in_w0 = byte'($urandom); bus.in_d0 = byte'($urandom);
        bus.in_last = 1'($urandom);
        @(posedge clk); #1;
        check("mac_en_single", bus.mac_en, 1'b0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic get_result(input logic [31:0] exp_data, input int exp_cnt, input int delay);
        int waited = 0;
        @(negedge clk);
        while (!bus.res_valid && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check("res_valid", bus.res_valid, 1'b1);
        check("res_data", bus.res_data, exp_data);
        check("res_count", bus.res_count, exp_cnt);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check("bp_res_valid", bus.res_valid, 1'b1);
            check("bp_res_data", bus.res_data, exp_data);
            check("bp_in_ready", bus.in_ready, 1'b0);
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        check("res_valid_drop", bus.res_valid, 1'b0);
        check("post_res_in_ready", bus.in_ready, 1'b1);
        check("post_res_count", bus.res_count, 0);
    endtask

    task automatic run_vector(input int n, input int bias, input int delay);
        int exp_sum;
        int en0;
        exp_sum = BIAS_ON ? bias : 0;
        for (int t = 0; t < n; t++)
            for (int k = 0; k < 3; k++)
                exp_sum += int'(vw[t][k]) * int'(vd[t][k]);
        en0 = mac_en_total;
        for (int t = 0; t < n; t++) begin
`ifdef MAC_SEQ_BIAS_EN
            bias_in = (t == 0) ? bias : $urandom;
`endif
            send_triplet(t, t == n - 1);
        end
        get_result(exp_sum, n, delay);
        check("mac_en_pulses", mac_en_total - en0, n);
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        int ofs;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.res_ready = 1'b0;
        bus.in_w0 = '0; bus.in_w1 = '0; bus.in_w2 = '0;
        bus.in_d0 = '0; bus.in_d1 = '0; bus.in_d2 = '0;
`ifdef MAC_SEQ_BIAS_EN
        bias_in = '0;
`endif
        ofs = BIAS_ON ? 100 : 0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_mac_en", bus.mac_en, 1'b0);
        check("rst_res_valid", bus.res_valid, 1'b0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_res_count", bus.res_count, 0);
        check("rst_pre_sum", bus.mac_pre_sum, 0);
        rstn = 1'b1;

        // one-triplet vector: 1*4+2*5+3*6 = 32
        vw[0] = '{8'sd1, 8'sd2, 8'sd3}; vd[0] = '{8'sd4, 8'sd5, 8'sd6};
        pre_q.delete();
        run_vector(1, 100, 0);
        check("t1_pre_sum", pre_q[0], ofs);

        // two triplets chained: 32 + (-3) = 29, second pre_sum carries 32
        vw[1] = '{-8'sd1, -8'sd1, -8'sd1}; vd[1] = '{8'sd1, 8'sd1, 8'sd1};
        pre_q.delete();
        run_vector(2, -5, 0);
        check("t2_pre_sum0", pre_q[0], BIAS_ON ? -5 : 0);
        check("t2_pre_sum1", pre_q[1], BIAS_ON ? 27 : 32);

        // signed: 5 * -3 = -15
        vw[0] = '{8'sd5, 8'sd0, 8'sd0}; vd[0] = '{-8'sd3, 8'sd0, 8'sd0};
        run_vector(1, 0, 0);

        // backpressure for 10 cycles, then a following vector must be intact
        vw[0] = '{8'sd7, -8'sd8, 8'sd9}; vd[0] = '{8'sd10, 8'sd11, -8'sd12};
        vw[1] = '{-8'sd128, 8'sd127, -8'sd128}; vd[1] = '{-8'sd128, 8'sd127, 8'sd127};
        run_vector(2, 17, 10);
        vw[0] = '{8'sd2, 8'sd2, 8'sd2}; vd[0] = '{8'sd3, 8'sd3, 8'sd3};
        run_vector(1, 0, 0);

        // randomized vectors
        for (int v = 0; v < 8; v++) begin
            n = int'($urandom_range(1, 6));
            for (int t = 0; t < n; t++)
                for (int k = 0; k < 3; k++) begin
                    vw[t][k] = byte'($urandom);
                    vd[t][k] = byte'($urandom);
                end
            run_vector(n, int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 3)));
        end

        // async reset while the MAC is busy discards the partial vector
        force_lat = 8;
        vw[0] = '{8'sd9, 8'sd9, 8'sd9}; vd[0] = '{8'sd9, 8'sd9, 8'sd9};
`ifdef MAC_SEQ_BIAS_EN
        bias_in = 32'd55;
`endif
        send_triplet(0, 1'b0);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("arst_in_ready", bus.in_ready, 1'b1);
        check("arst_mac_en", bus.mac_en, 1'b0);
        check("arst_res_valid", bus.res_valid, 1'b0);
        check("arst_res_data", bus.res_data, 0);
        check("arst_res_count", bus.res_count, 0);
        check("arst_pre_sum", bus.mac_pre_sum, 0);
        check("arst_mac_w0", bus.mac_w0, 0);
        check("arst_mac_d2", bus.mac_d2, 0);
        force_lat = -1;
        @(negedge clk);
        rstn = 1'b1;
        vw[0] = '{8'sd1, 8'sd1, 8'sd1}; vd[0] = '{8'sd1, 8'sd1, 8'sd1};
        run_vector(1, 7, 0);

        check("no_mac_overlap", overlap_err, 0);
        check("mac_operands_held", hold_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
